// File: rtl/bitty_sequencer.sv
// rtl/bitty_sequencer.sv - instruction fetch/issue sequencer for the bitty core
// Optional single-step support is enabled with `define BITTY_SINGLE_STEP_EN.
module bitty_sequencer #(
    parameter int          PROG_DEPTH  = 256,
    parameter int          ADDR_W      = $clog2(PROG_DEPTH),
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF,
    parameter int          TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
`ifdef BITTY_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              core_done,
    output logic              core_run,
    output logic [15:0]       core_instr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(PROG_DEPTH - 1);
    localparam logic [9:0]        TIMEOUT_M1 = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT,
`ifdef BITTY_SINGLE_STEP_EN
        S_PAUSE,
`endif
        S_ERR
    } state_t;

    state_t      state;
    logic [9:0]  wd_count;
    logic [15:0] mem [PROG_DEPTH];
    logic [15:0] fetch_word;

    // Program memory is never reset; writes are only accepted while stopped.
    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    assign fetch_word = mem[pc];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            core_run   <= 1'b0;
            core_instr <= 16'h0000;
            pc         <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            error      <= 1'b0;
            wd_count   <= '0;
        end else begin
            core_run <= 1'b0;
            case (state)
                S_IDLE, S_HALT, S_ERR: begin
                    if (start) begin
                        pc     <= '0;
                        halted <= 1'b0;
                        error  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // A halt word is consumed here and never reaches the core.
                    if (fetch_word == HALT_OPCODE) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        core_instr <= fetch_word;
                        core_run   <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_count <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        if (halt_req || pc == LAST_PC) begin
                            busy   <= 1'b0;
                            halted <= 1'b1;
                            state  <= S_HALT;
`ifdef BITTY_SINGLE_STEP_EN
                        end else if (step_mode) begin
                            pc    <= pc + 1'b1;
                            state <= S_PAUSE;
`endif
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end else if (wd_count == TIMEOUT_M1) begin
                        wd_count <= wd_count + 1'b1;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
`ifdef BITTY_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (halt_req) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (step) begin
                        state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_sequencer.sv
// tb/tb_bitty_sequencer.sv - directed vector bench for bitty_sequencer
module tb_bitty_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          halt_req;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          core_done;
    logic          core_run;
    logic [15:0]   core_instr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          error;
`ifdef BITTY_SINGLE_STEP_EN
    logic          step_mode = 1'b0;
    logic          step      = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitty_sequencer #(
        .PROG_DEPTH (DEPTH),
        .ADDR_W     (AW),
        .HALT_OPCODE(16'hFFFF),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .halt_req  (halt_req),
`ifdef BITTY_SINGLE_STEP_EN
        .step_mode (step_mode),
        .step      (step),
`endif
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .core_done (core_done),
        .core_run  (core_run),
        .core_instr(core_instr),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .error     (error)
    );

    typedef struct {
        logic          st;
        logic          hr;
        logic          le;
        logic [AW-1:0] la;
        logic [15:0]   ld;
        logic          dn;
        logic          run;
        logic [15:0]   instr;
        logic [AW-1:0] pc;
        logic          busy;
        logic          halted;
        logic          error;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_run(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (core_run) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic complete_instr();
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic count_runs(input string name, input int cycles);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            if (core_run) n++;
            tick();
        end
        chk(name, 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        //          st    hr    le    la    ld        dn    run   instr     pc    busy  hlt   err
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'd0, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'd1, 16'h5678, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'd2, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h1234, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h1234, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h1234, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h1234, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h5678, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h5678, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h5678, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h5678, 4'd2, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h5678, 4'd2, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h5678, 4'd2, 1'b0, 1'b1, 1'b0};

        reset     = 1'b1;
        start     = 1'b0;
        halt_req  = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = 16'h0000;
        core_done = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 32'({core_run, core_instr, pc, busy, halted, error}), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", 32'({core_run, core_instr, pc, busy, halted, error}), 32'd0);

        // Program 0x1234, 0x5678, halt; done returned three cycles after each run.
        for (int i = 0; i < 14; i++) begin
            start     = tbl[i].st;
            halt_req  = tbl[i].hr;
            load_en   = tbl[i].le;
            load_addr = tbl[i].la;
            load_data = tbl[i].ld;
            core_done = tbl[i].dn;
            tick();
            chk($sformatf("vec%0d", i),
                32'({core_run, core_instr, pc, busy, halted, error}),
                32'({tbl[i].run, tbl[i].instr, tbl[i].pc, tbl[i].busy, tbl[i].halted, tbl[i].error}));
        end
        start     = 1'b0;
        load_en   = 1'b0;
        core_done = 1'b0;
        count_runs("no_third_run", 6);

        // Watchdog timeout and recovery.
        load_word(4'd0, 16'h0001);
        pulse_start();
        wait_run("to_first_run");
        n = 0;
        while (!error && n < 50) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 32'(TMO + 1));
        chk("to_flags", 32'({busy, halted, error}), 32'b001);
        pulse_start();
        chk("to_error_cleared", 32'({busy, error}), 32'b10);
        wait_run("to_rerun");
        chk("to_reissue", 32'(core_instr), 32'h0001);
        tick();
        halt_req  = 1'b1;
        core_done = 1'b1;
        tick();
        halt_req  = 1'b0;
        core_done = 1'b0;

        // halt_req raised during WAIT of address 5.
        for (int i = 0; i < 7; i++) load_word(AW'(i), 16'h0010 + 16'(i));
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            wait_run($sformatf("hr_run%0d", i));
            chk($sformatf("hr_instr%0d", i), 32'(core_instr), 32'h0010 + 32'(i));
            tick();
            if (i == 5) halt_req = 1'b1;
            complete_instr();
            halt_req = 1'b0;
        end
        chk("hr_halted", 32'({busy, halted, error}), 32'b010);
        chk("hr_pc", 32'(pc), 32'd5);
        count_runs("hr_no_more_runs", 8);

        // Full memory of non-halt words stops at the last address without wrapping.
        for (int i = 0; i < DEPTH; i++) load_word(AW'(i), 16'h0000);
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            wait_run($sformatf("end_run%0d", i));
            chk($sformatf("end_pc%0d", i), 32'(pc), 32'(i));
            complete_instr();
        end
        chk("end_halted", 32'({busy, halted, error}), 32'b010);
        chk("end_pc_final", 32'(pc), 32'(DEPTH - 1));
        count_runs("end_no_wrap", 8);

        // Asynchronous reset mid-WAIT, memory retained.
        load_word(4'd0, 16'h00C3);
        load_word(4'd1, 16'h00C4);
        load_word(4'd2, 16'h00C5);
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            wait_run($sformatf("rst_run%0d", i));
            complete_instr();
        end
        wait_run("rst_run2");
        tick();
        chk("rst_pre", 32'({busy, pc}), 32'({1'b1, 4'd2}));
        #2 reset = 1'b1;
        #1 chk("rst_async", 32'({core_run, busy, pc, core_instr}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse_start();
        wait_run("rst_rerun");
        chk("rst_mem_kept", 32'(core_instr), 32'h00C3);

        // Load attempts while busy are dropped.
        tick();
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 16'hAAAA;
        tick();
        tick();
        load_en   = 1'b0;
        halt_req  = 1'b1;
        core_done = 1'b1;
        tick();
        halt_req  = 1'b0;
        core_done = 1'b0;
        chk("busy_load_halted", 32'(halted), 32'd1);
        pulse_start();
        wait_run("busy_load_rerun");
        chk("busy_load_dropped", 32'(core_instr), 32'h00C3);
        tick();
        halt_req  = 1'b1;
        core_done = 1'b1;
        tick();
        halt_req  = 1'b0;
        core_done = 1'b0;

        // Load and start in the same cycle: the new word is the first fetched.
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 16'h0BEE;
        start     = 1'b1;
        tick();
        load_en   = 1'b0;
        start     = 1'b0;
        wait_run("ls_run");
        chk("ls_instr", 32'(core_instr), 32'h0BEE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
